// File: rtl/morse_pkg.sv
// Shared constants, FSM encoding and the ITU Morse lookup for the key decoder.
// Lookup key is {len, bits} with the first symbol at bit len-1; dot=0, dash=1.
package morse_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_QMARK = 8'h3F;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_PRESS     = 2'd1;
  localparam state_t ST_GAP       = 2'd2;
  localparam state_t ST_WAIT_WORD = 2'd3;

  // Returns {valid, ascii}; valid=0 means the code has no character.
  function automatic logic [8:0] morse_lookup(input logic [2:0] len, input logic [4:0] bits);
    logic [7:0] c;
    c = 8'h00;
    case ({len, bits})
      {3'd2, 5'b00001}: c = 8'h41; // A
      {3'd4, 5'b01000}: c = 8'h42; // B
      {3'd4, 5'b01010}: c = 8'h43; // C
      {3'd3, 5'b00100}: c = 8'h44; // D
      {3'd1, 5'b00000}: c = 8'h45; // E
      {3'd4, 5'b00010}: c = 8'h46; // F
      {3'd3, 5'b00110}: c = 8'h47; // G
      {3'd4, 5'b00000}: c = 8'h48; // H
      {3'd2, 5'b00000}: c = 8'h49; // I
      {3'd4, 5'b00111}: c = 8'h4A; // J
      {3'd3, 5'b00101}: c = 8'h4B; // K
      {3'd4, 5'b00100}: c = 8'h4C; // L
      {3'd2, 5'b00011}: c = 8'h4D; // M
      {3'd2, 5'b00010}: c = 8'h4E; // N
      {3'd3, 5'b00111}: c = 8'h4F; // O
      {3'd4, 5'b00110}: c = 8'h50; // P
      {3'd4, 5'b01101}: c = 8'h51; // Q
      {3'd3, 5'b00010}: c = 8'h52; // R
      {3'd3, 5'b00000}: c = 8'h53; // S
      {3'd1, 5'b00001}: c = 8'h54; // T
      {3'd3, 5'b00001}: c = 8'h55; // U
      {3'd4, 5'b00001}: c = 8'h56; // V
      {3'd3, 5'b00011}: c = 8'h57; // W
      {3'd4, 5'b01001}: c = 8'h58; // X
      {3'd4, 5'b01011}: c = 8'h59; // Y
      {3'd4, 5'b01100}: c = 8'h5A; // Z
      {3'd5, 5'b11111}: c = 8'h30;
      {3'd5, 5'b01111}: c = 8'h31;
      {3'd5, 5'b00111}: c = 8'h32;
      {3'd5, 5'b00011}: c = 8'h33;
      {3'd5, 5'b00001}: c = 8'h34;
      {3'd5, 5'b00000}: c = 8'h35;
      {3'd5, 5'b10000}: c = 8'h36;
      {3'd5, 5'b11000}: c = 8'h37;
      {3'd5, 5'b11100}: c = 8'h38;
      {3'd5, 5'b11110}: c = 8'h39;
      default:          c = 8'h00;
    endcase
    return {c != 8'h00, c};
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// 2-FF synchroniser plus debounce: key_level_o flips only after DEBOUNCE_CYC
// consecutive cycles of the synchronised key disagreeing with it.
module key_debouncer #(
  parameter int DEBOUNCE_CYC = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic key_level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign key_level_o = level_q;

endmodule

// File: rtl/morse_key_decoder.sv
// Times debounced key presses/gaps, assembles dot/dash symbols and emits one
// ASCII character per letter gap (space on word gap), one cycle after the threshold.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 5000,
  parameter int DOT_MAX_CYC    = 200000,
  parameter int LETTER_GAP_CYC = 400000,
  parameter int WORD_GAP_CYC   = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       symbol_err,
  output logic       key_level,
  output logic [2:0] sym_len
);

  logic             level, level_prev_q;
  logic             rise, fall;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] press_q, press_d, gap_q, gap_d;
  logic [4:0]       bits_q, bits_d;
  logic [2:0]       len_q, len_d;
  logic             ovf_q, ovf_d, armed_q, armed_d;
  logic [7:0]       char_q;
  logic             valid_q, err_q;
  logic             emit, emit_err;
  logic [7:0]       emit_char;
  logic [8:0]       lut;
  logic             dash;

  key_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk         (clk),
    .rst         (rst),
    .key_i       (key_in),
    .key_level_o (level)
  );

  assign rise = level & ~level_prev_q;
  assign fall = ~level & level_prev_q;
  assign lut  = morse_lookup(len_q, bits_q);
  assign dash = press_q >= CNT_W'(DOT_MAX_CYC);

  always_comb begin
    state_d   = state_q;
    press_d   = press_q;
    gap_d     = gap_q;
    bits_d    = bits_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    armed_d   = armed_q;
    emit      = 1'b0;
    emit_err  = 1'b0;
    emit_char = CH_SPACE;
    case (state_q)
      ST_IDLE: begin
        press_d = '0;
        gap_d   = '0;
        if (rise) state_d = ST_PRESS;
      end
      ST_PRESS: begin
        if (!(&press_q)) press_d = press_q + CNT_W'(1);
        if (fall) begin
          if (len_q < 3'd5) begin
            bits_d = {bits_q[3:0], dash};
            len_d  = len_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!(&gap_q)) gap_d = gap_q + CNT_W'(1);
        // The letter closes even if a new press arrives in the same cycle.
        if (gap_q == CNT_W'(LETTER_GAP_CYC)) begin
          emit      = 1'b1;
          emit_err  = ovf_q | ~lut[8];
          emit_char = emit_err ? CH_QMARK : lut[7:0];
          bits_d    = '0;
          len_d     = '0;
          ovf_d     = 1'b0;
          armed_d   = 1'b1;
          state_d   = ST_WAIT_WORD;
        end
        if (rise) begin
          press_d = '0;
          state_d = ST_PRESS;
        end
      end
      default: begin
        if (!(&gap_q)) gap_d = gap_q + CNT_W'(1);
        if (armed_q && gap_q == CNT_W'(WORD_GAP_CYC)) begin
          emit    = 1'b1;
          armed_d = 1'b0;
        end
        if (rise) begin
          press_d = '0;
          state_d = ST_PRESS;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      press_q      <= '0;
      gap_q        <= '0;
      bits_q       <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      armed_q      <= 1'b0;
      char_q       <= CH_SPACE;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      level_prev_q <= level;
      state_q      <= state_d;
      press_q      <= press_d;
      gap_q        <= gap_d;
      bits_q       <= bits_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      armed_q      <= armed_d;
      if (emit) char_q <= emit_char;
      valid_q      <= emit;
      err_q        <= emit & emit_err;
    end
  end

  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign symbol_err = err_q;
  assign key_level  = level;
  assign sym_len    = len_q;

endmodule
